reg_seq_ctrl: RTL and testbench

Two-requester command sequencer for the multi-mode register (R9-style datapath: sync clear, sync load, write-d, decrement).
- Arbitrates between two requesters, round-robin.
- Drives the register's synchronous control lines so that each granted command executes atomically.
- Acknowledges each command with a one-cycle pulse.
- Register async inputs are tied off at the parent: clr=1, load=0.

---
 rtl/reg_seq_pkg.sv | 49 ++++
 rtl/reg_seq_ctrl_rr_arb2.sv | 33 +++
 rtl/reg_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_reg_seq_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reg_seq_pkg.sv
// ============================================================================
// Module : reg_seq_pkg
// Brief  : Command, state and register-control encodings for reg_seq_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_seq_pkg;

  localparam logic [1:0] CMD_CLEAR     = 2'b00;
  localparam logic [1:0] CMD_LOAD      = 2'b01;
  localparam logic [1:0] CMD_WRITE     = 2'b10;
  localparam logic [1:0] CMD_COUNTDOWN = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_COUNT = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  // Synchronous control lines of the register; clr_s is active-low.
  typedef struct packed {
    logic en;
    logic clr_s;
    logic load_s;
  } ctrl_t;

  localparam ctrl_t CTRL_HOLD  = '{en: 1'b1, clr_s: 1'b1, load_s: 1'b0};
  localparam ctrl_t CTRL_CLEAR = '{en: 1'b1, clr_s: 1'b0, load_s: 1'b0};
  localparam ctrl_t CTRL_LOAD  = '{en: 1'b1, clr_s: 1'b1, load_s: 1'b1};
  localparam ctrl_t CTRL_WRITE = '{en: 1'b1, clr_s: 1'b1, load_s: 1'b0};
  localparam ctrl_t CTRL_DEC   = '{en: 1'b0, clr_s: 1'b1, load_s: 1'b0};

  // COUNTDOWN only holds in its first cycle; the decrements come later.
  function automatic ctrl_t cmd_ctrl(input logic [1:0] cmd);
    ctrl_t c;
    case (cmd)
      CMD_CLEAR: c = CTRL_CLEAR;
      CMD_LOAD:  c = CTRL_LOAD;
      CMD_WRITE: c = CTRL_WRITE;
      default:   c = CTRL_HOLD;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_seq_ctrl_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-input round-robin arbiter; pointer names the favoured input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic       gnt_id_o,
  output logic       valid_o
);

  logic ptr_q;

  assign valid_o  = |req_i;
  assign gnt_id_o = (req_i == 2'b11) ? ptr_q : req_i[1];

  // After every grant the loser becomes the favoured input.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q <= 1'b0;
    end else if (upd_i && valid_o) begin
      ptr_q <= ~gnt_id_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_seq_ctrl.sv
// ============================================================================
// Module : reg_seq_ctrl
// Brief  : Two-requester sequencer driving a clear/load/write/decrement register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_seq_ctrl
  import reg_seq_pkg::*;
#(
  parameter int LEN       = 2,
  parameter int MAX_STEPS = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [1:0]     req_i,
  input  logic [1:0]     cmd0_i,
  input  logic [1:0]     cmd1_i,
  input  logic [LEN-1:0] opd0_i,
  input  logic [LEN-1:0] opd1_i,
  output logic [1:0]     ack_o,
  output logic           busy_o,
  output logic           gnt_id_o,
  input  logic [LEN-1:0] reg_q_i,
  output logic           reg_clr_s_o,
  output logic           reg_load_s_o,
  output logic           reg_clk_enable_o,
  output logic [LEN-1:0] reg_data_o,
  output logic [LEN-1:0] reg_d_o
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] STEP_CAP = STEP_W'(MAX_STEPS);

  state_e            state_q;
  logic [1:0]        cmd_q;
  logic [LEN-1:0]    opd_q;
  logic [STEP_W-1:0] step_q;
  logic [1:0]        ack_q;
  logic              busy_q;
  logic              gnt_id_q;

  logic  arb_gnt;
  logic  arb_valid;
  logic  grant;
  logic  count_done;
  ctrl_t ctrl;

  assign grant      = (state_q == S_IDLE) && arb_valid;
  assign count_done = (reg_q_i == '0) || (step_q == STEP_CAP);

  rr_arb2 u_arb (
    .clk      (clk),
    .clr      (clr),
    .req_i    (req_i),
    .upd_i    (grant),
    .gnt_id_o (arb_gnt),
    .valid_o  (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      cmd_q    <= CMD_CLEAR;
      opd_q    <= '0;
      step_q   <= '0;
      ack_q    <= 2'b00;
      busy_q   <= 1'b0;
      gnt_id_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 2'b00;
          if (arb_valid) begin
            gnt_id_q <= arb_gnt;
            cmd_q    <= arb_gnt ? cmd1_i : cmd0_i;
            opd_q    <= arb_gnt ? opd1_i : opd0_i;
            busy_q   <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cmd_q == CMD_COUNTDOWN) begin
            step_q  <= '0;
            state_q <= S_COUNT;
          end else begin
            ack_q[gnt_id_q] <= 1'b1;
            state_q         <= S_ACK;
          end
        end
        S_COUNT: begin
          if (count_done) begin
            ack_q[gnt_id_q] <= 1'b1;
            state_q         <= S_ACK;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        default: begin
          ack_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Reset overrides the state so the register is cleared on the same edge.
  always_comb begin
    ctrl       = CTRL_HOLD;
    reg_data_o = '0;
    reg_d_o    = reg_q_i;
    if (clr) begin
      ctrl    = CTRL_CLEAR;
      reg_d_o = '0;
    end else begin
      case (state_q)
        S_EXEC: begin
          ctrl = cmd_ctrl(cmd_q);
          case (cmd_q)
            CMD_CLEAR: reg_d_o = '0;
            CMD_LOAD: begin
              reg_data_o = opd_q;
              reg_d_o    = '0;
            end
            CMD_WRITE: reg_d_o = opd_q;
            default: ;
          endcase
        end
        S_COUNT: begin
          if (!count_done) begin
            ctrl    = CTRL_DEC;
            reg_d_o = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_clk_enable_o = ctrl.en;
  assign reg_clr_s_o      = ctrl.clr_s;
  assign reg_load_s_o     = ctrl.load_s;
  assign ack_o            = ack_q;
  assign busy_o           = busy_q;
  assign gnt_id_o         = gnt_id_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_seq_ctrl.sv
// ============================================================================
// Module : tb_reg_seq_ctrl
// Brief  : Randomised bench with a register plant and a transaction-timeline model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_seq_ctrl;

  localparam int LEN       = 2;
  localparam int MAX_STEPS = 4;
  localparam int N_CYCLES  = 4000;

  logic           clk = 1'b0;
  logic           clr;
  logic [1:0]     req_i;
  logic [1:0]     cmd0_i, cmd1_i;
  logic [LEN-1:0] opd0_i, opd1_i;
  logic [1:0]     ack_o;
  logic           busy_o, gnt_id_o;
  logic [LEN-1:0] plant_q;
  logic           reg_clr_s_o, reg_load_s_o, reg_clk_enable_o;
  logic [LEN-1:0] reg_data_o, reg_d_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  reg_seq_ctrl #(.LEN(LEN), .MAX_STEPS(MAX_STEPS)) dut (
    .clk              (clk),
    .clr              (clr),
    .req_i            (req_i),
    .cmd0_i           (cmd0_i),
    .cmd1_i           (cmd1_i),
    .opd0_i           (opd0_i),
    .opd1_i           (opd1_i),
    .ack_o            (ack_o),
    .busy_o           (busy_o),
    .gnt_id_o         (gnt_id_o),
    .reg_q_i          (plant_q),
    .reg_clr_s_o      (reg_clr_s_o),
    .reg_load_s_o     (reg_load_s_o),
    .reg_clk_enable_o (reg_clk_enable_o),
    .reg_data_o       (reg_data_o),
    .reg_d_o          (reg_d_o)
  );

  task automatic chk_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: each command is a timeline measured from its grant cycle.
  bit             m_known = 1'b0;
  bit             m_busy  = 1'b0;
  bit             m_gnt, m_rr;
  logic [1:0]     m_cmd;
  logic [LEN-1:0] m_opd;
  logic [LEN-1:0] m_q = 2'b11;
  int             m_t, m_len, m_k;

  bit             pend [2];
  logic [1:0]     rc   [2];
  logic [LEN-1:0] ro   [2];

  logic [1:0]     e_ack;
  logic           e_en, e_clr_s, e_load_s;
  logic [LEN-1:0] e_data, e_d, plant_nxt;

  initial begin
    plant_q = 2'b11;
    pend[0] = 1'b0; pend[1] = 1'b0;
    rc[0] = 2'b00; rc[1] = 2'b00; ro[0] = '0; ro[1] = '0;
    m_gnt = 1'b0; m_rr = 1'b0; m_cmd = 2'b00; m_opd = '0;
    m_t = 0; m_len = 0; m_k = 0;
    clr = 1'b1; req_i = 2'b00;
    cmd0_i = 2'b00; cmd1_i = 2'b00; opd0_i = '0; opd1_i = '0;
    @(posedge clk); #1;

    for (cyc = 0; cyc < N_CYCLES; cyc++) begin
      // Stimulus for this cycle.
      clr = (cyc < 2) || ($urandom_range(0, 99) < 2);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          if ($urandom_range(0, 99) < 45) begin
            pend[r] = 1'b1;
            rc[r]   = 2'($urandom_range(0, 3));
            ro[r]   = LEN'($urandom_range(0, 3));
          end
        end else if (m_busy && (int'(m_gnt) == r) && ($urandom_range(0, 99) < 40)) begin
          rc[r] = 2'($urandom_range(0, 3));
          ro[r] = LEN'($urandom_range(0, 3));
        end
      end
      req_i  = {pend[1], pend[0]};
      cmd0_i = rc[0]; cmd1_i = rc[1];
      opd0_i = ro[0]; opd1_i = ro[1];

      // Expected outputs for this cycle.
      e_ack    = (m_busy && m_t == m_len) ? (2'b01 << m_gnt) : 2'b00;
      e_en     = 1'b1; e_clr_s = 1'b1; e_load_s = 1'b0;
      e_data   = '0;   e_d     = m_q;
      if (clr) begin
        e_clr_s = 1'b0; e_d = '0;
      end else if (m_busy) begin
        if (m_t == 1 && m_cmd == 2'b00) begin
          e_clr_s = 1'b0; e_d = '0;
        end else if (m_t == 1 && m_cmd == 2'b01) begin
          e_load_s = 1'b1; e_data = m_opd; e_d = '0;
        end else if (m_t == 1 && m_cmd == 2'b10) begin
          e_d = m_opd;
        end else if (m_cmd == 2'b11 && m_t >= 2 && m_t <= 1 + m_k) begin
          e_en = 1'b0; e_d = '0;
        end
      end

      @(negedge clk);
      if (m_known) begin
        chk_val("ack", ack_o, e_ack);
        chk_val("busy", busy_o, m_busy);
        if (m_busy) chk_val("gnt_id", gnt_id_o, m_gnt);
      end
      chk_val("clr_s", reg_clr_s_o, e_clr_s);
      chk_val("load_s", reg_load_s_o, e_load_s);
      chk_val("enable", reg_clk_enable_o, e_en);
      chk_val("data", reg_data_o, e_data);
      chk_val("d", reg_d_o, e_d);
      chk_val("reg_q", plant_q, m_q);

      // The register itself, driven by whatever the DUT is presenting.
      if (!reg_clr_s_o)           plant_nxt = '0;
      else if (!reg_clk_enable_o) plant_nxt = plant_q - 1'b1;
      else if (reg_load_s_o)      plant_nxt = reg_data_o;
      else                        plant_nxt = reg_d_o;

      for (int r = 0; r < 2; r++) if (e_ack[r]) pend[r] = 1'b0;

      // Advance the reference across the coming edge.
      if (clr) begin
        m_known = 1'b1; m_busy = 1'b0; m_rr = 1'b0; m_q = '0;
      end else if (!m_busy) begin
        if (req_i != 2'b00) begin
          m_gnt  = (req_i == 2'b11) ? m_rr : req_i[1];
          m_rr   = ~m_gnt;
          m_cmd  = m_gnt ? cmd1_i : cmd0_i;
          m_opd  = m_gnt ? opd1_i : opd0_i;
          m_k    = (int'(m_q) > MAX_STEPS) ? MAX_STEPS : int'(m_q);
          m_len  = (m_cmd == 2'b11) ? 3 + m_k : 2;
          m_t    = 1;
          m_busy = 1'b1;
        end
      end else begin
        if (m_t == 1 && m_cmd == 2'b00) m_q = '0;
        else if (m_t == 1 && (m_cmd == 2'b01 || m_cmd == 2'b10)) m_q = m_opd;
        else if (m_cmd == 2'b11 && m_t >= 2 && m_t <= 1 + m_k) m_q = m_q - 1'b1;
        if (m_t == m_len) m_busy = 1'b0;
        else m_t++;
      end

      @(posedge clk); #1;
      plant_q = plant_nxt;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
